// File: rtl/tone_keypad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tone_keypad                                                  |
// | Description : N-button tone generator. Synchronised and debounced buttons  |
// |               are arbitrated lowest-index-first. Hold mode plays while a   |
// |               button is held. One-shot mode plays a fixed-length beep for  |
// |               each press. Drives the buzzer, one-hot LEDs and the "b<n>"   |
// |               hexdigit codes.                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tone_keypad #(
   parameter int                    NBTN      = 4,
   parameter int                    DIV_W     = 16,
   parameter logic [NBTN*DIV_W-1:0] DIV_TABLE = {16'd3999, 16'd3199, 16'd2999, 16'd2499},
   parameter int                    DEB_CYC   = 100000,
   parameter int                    BEEP_CYC  = 2000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NBTN-1:0] prbtn,
   input  logic            mode,
   output logic [NBTN-1:0] prled,
   output logic [4:0]      dig1,
   output logic [4:0]      dig0,
   output logic            prbuz,
   output logic            busy
);

   localparam int CH_W   = (NBTN > 1) ? $clog2(NBTN) : 1;
   localparam int DEB_W  = $clog2(DEB_CYC + 1);
   localparam int BEEP_W = $clog2(BEEP_CYC + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
   localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYC - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_BEEP = 2'd2;
   localparam logic [1:0] ST_WAIT = 2'd3;

   localparam logic [4:0] DIG_OFF = 5'd20;
   localparam logic [4:0] DIG_B   = 5'd11;

   logic [NBTN-1:0]   pressed;
   logic [DIV_W-1:0]  div_tab [NBTN];

   logic [CH_W-1:0]   sel;
   logic              any;
   logic              any_q;
   logic              new_press;

   logic [1:0]        state, state_nx;
   logic [CH_W-1:0]   ch, ch_nx;
   logic [BEEP_W-1:0] beep_cnt, beep_nx;

   logic [DIV_W-1:0]  div_cnt;
   logic [DIV_W-1:0]  div_cur;
   logic              tone_on_nx;
   logic              restart;

   logic [NBTN-1:0]   led_nx;
   logic [4:0]        dig1_nx, dig0_nx;
   logic              busy_nx;

   genvar gi;
   generate
      for (gi = 0; gi < NBTN; gi++) begin : g_btn
         logic             sync1;
         logic             sync2;
         logic             deb;
         logic [DEB_W-1:0] deb_cnt;

         // Two-flop synchroniser plus debounce: the level is accepted only after
         // DEB_CYC consecutive differing samples.
         always_ff @(posedge clk) begin
            if (!rst) begin
               sync1   <= 1'b1;
               sync2   <= 1'b1;
               deb     <= 1'b1;
               deb_cnt <= '0;
            end else begin
               sync1 <= prbtn[gi];
               sync2 <= sync1;
               if (sync2 != deb) begin
                  if (deb_cnt == DEB_LAST) begin
                     deb     <= sync2;
                     deb_cnt <= '0;
                  end else begin
                     deb_cnt <= deb_cnt + 1'b1;
                  end
               end else begin
                  deb_cnt <= '0;
               end
            end
         end

         assign pressed[gi] = ~deb;
         assign div_tab[gi] = DIV_TABLE[gi*DIV_W +: DIV_W];
      end
   endgenerate

   // Priority arbitration: the lowest-index pressed button wins.
   always_comb begin
      sel = '0;
      for (int i = NBTN - 1; i >= 0; i--) begin
         if (pressed[i]) sel = CH_W'(i);
      end
   end

   assign any       = |pressed;
   assign new_press = any & ~any_q;

   // FSM state register, together with the channel and beep timer it owns.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         ch       <= '0;
         beep_cnt <= '0;
         any_q    <= 1'b0;
      end else begin
         state    <= state_nx;
         ch       <= ch_nx;
         beep_cnt <= beep_nx;
         any_q    <= any;
      end
   end

   // Next-state logic. Mode is only consulted in IDLE.
   always_comb begin
      state_nx = state;
      ch_nx    = ch;
      beep_nx  = beep_cnt;
      case (state)
         ST_IDLE: begin
            if (!mode && any) begin
               state_nx = ST_HOLD;
               ch_nx    = sel;
            end else if (mode && new_press) begin
               state_nx = ST_BEEP;
               ch_nx    = sel;
               beep_nx  = BEEP_LOAD;
            end
         end
         ST_HOLD: begin
            if (!any)            state_nx = ST_IDLE;
            else if (sel != ch)  ch_nx    = sel;
         end
         ST_BEEP: begin
            if (beep_cnt == '0) state_nx = ST_WAIT;
            else                beep_nx  = beep_cnt - 1'b1;
         end
         ST_WAIT: begin
            if (!any) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Output decode from the current state; registered one cycle later below.
   always_comb begin
      led_nx  = '0;
      dig1_nx = DIG_OFF;
      dig0_nx = DIG_OFF;
      busy_nx = (state != ST_IDLE);
      if (state == ST_HOLD || state == ST_BEEP) begin
         led_nx  = NBTN'(1) << ch;
         dig1_nx = DIG_B;
         dig0_nx = 5'(ch);
      end
   end

   // Registered LED, digit and busy outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         prled <= '0;
         dig1  <= DIG_OFF;
         dig0  <= DIG_OFF;
         busy  <= 1'b0;
      end else begin
         prled <= led_nx;
         dig1  <= dig1_nx;
         dig0  <= dig0_nx;
         busy  <= busy_nx;
      end
   end

   // The divider restarts on entry to a tone state or on a channel switch, so
   // the first rising buzzer edge always lands div+1 cycles after the restart.
   assign div_cur    = div_tab[ch];
   assign tone_on_nx = (state_nx == ST_HOLD) || (state_nx == ST_BEEP);
   assign restart    = (state_nx != state) || (ch_nx != ch);

   // Half-period tone divider driving the buzzer square wave.
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt <= '0;
         prbuz   <= 1'b0;
      end else if (!tone_on_nx || restart || (div_cur == '0)) begin
         div_cnt <= '0;
         prbuz   <= 1'b0;
      end else if (div_cnt == div_cur) begin
         div_cnt <= '0;
         prbuz   <= ~prbuz;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tone_keypad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tone_keypad                                               |
// | Description : Directed vector bench for tone_keypad. Covers reset, hold    |
// |               mode, arbitration, glitch rejection, one-shot beep and reset |
// |               during a beep.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tone_keypad;

   logic       clk;
   logic       rst;
   logic [3:0] prbtn;
   logic       mode;
   logic [3:0] prled;
   logic [4:0] dig1;
   logic [4:0] dig0;
   logic       prbuz;
   logic       busy;

   int n_cmp  = 0;
   int n_fail = 0;

   tone_keypad #(
      .NBTN      (4),
      .DIV_W     (16),
      .DIV_TABLE ({16'd9, 16'd7, 16'd5, 16'd3}),
      .DEB_CYC   (4),
      .BEEP_CYC  (40)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .prbtn (prbtn),
      .mode  (mode),
      .prled (prled),
      .dig1  (dig1),
      .dig0  (dig0),
      .prbuz (prbuz),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [3:0] btn;
      logic       md;
      int         ncyc;
      logic [3:0] e_led;
      logic [4:0] e_d1;
      logic [4:0] e_d0;
      logic       e_busy;
      int         e_period;   // 0: no measurement, buzzer must read 0
      int         mon;        // 1: busy must stay 1, 2: everything must stay idle
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Cycles between two consecutive rising buzzer edges; -1 if none within bound.
   task automatic measure_period(output int per);
      int   first;
      logic prev;
      per   = -1;
      first = -1;
      prev  = prbuz;
      for (int cyc = 1; cyc <= 80; cyc++) begin
         @(negedge clk);
         if (!prev && prbuz) begin
            if (first < 0) begin
               first = cyc;
            end else begin
               per = cyc - first;
               break;
            end
         end
         prev = prbuz;
      end
   endtask

   logic       buz_h  [1:100];
   logic       busy_h [1:100];
   logic [3:0] led_h  [1:100];

   initial begin
      int   per;
      logic mon_bad;
      int   rises;

      vecs[0] = '{4'b1111, 1'b0,  3, 4'b0000, 5'd20, 5'd20, 1'b0,  0, 0};
      vecs[1] = '{4'b1110, 1'b0,  7, 4'b0000, 5'd20, 5'd20, 1'b0,  0, 0};
      vecs[2] = '{4'b1110, 1'b0,  1, 4'b0001, 5'd11, 5'd0,  1'b1,  8, 0};
      vecs[3] = '{4'b1111, 1'b0, 12, 4'b0000, 5'd20, 5'd20, 1'b0,  0, 0};
      vecs[4] = '{4'b1011, 1'b0, 10, 4'b0100, 5'd11, 5'd2,  1'b1, 16, 0};
      vecs[5] = '{4'b1001, 1'b0, 10, 4'b0010, 5'd11, 5'd1,  1'b1, 12, 0};
      vecs[6] = '{4'b1011, 1'b0, 10, 4'b0100, 5'd11, 5'd2,  1'b1, 16, 1};
      vecs[7] = '{4'b1111, 1'b0, 12, 4'b0000, 5'd20, 5'd20, 1'b0,  0, 0};
      vecs[8] = '{4'b1101, 1'b0,  3, 4'b0000, 5'd20, 5'd20, 1'b0,  0, 2};
      vecs[9] = '{4'b1111, 1'b0, 12, 4'b0000, 5'd20, 5'd20, 1'b0,  0, 2};

      // Reset with all buttons released.
      rst   = 1'b0;
      prbtn = 4'b1111;
      mode  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_led",  prled, 4'b0000);
      check("rst_buz",  prbuz, 1'b0);
      check("rst_dig1", dig1,  5'd20);
      check("rst_dig0", dig0,  5'd20);
      check("rst_busy", busy,  1'b0);
      rst = 1'b1;

      // Hold mode, arbitration and glitch vectors.
      for (int k = 0; k < NV; k++) begin
         prbtn   = vecs[k].btn;
         mode    = vecs[k].md;
         mon_bad = 1'b0;
         for (int c = 0; c < vecs[k].ncyc; c++) begin
            @(negedge clk);
            if (vecs[k].mon == 1 && busy !== 1'b1) mon_bad = 1'b1;
            if (vecs[k].mon == 2 && (busy !== 1'b0 || prled !== 4'b0000 || prbuz !== 1'b0))
               mon_bad = 1'b1;
         end
         check($sformatf("v%0d_led", k),  prled, vecs[k].e_led);
         check($sformatf("v%0d_dig1", k), dig1,  vecs[k].e_d1);
         check($sformatf("v%0d_dig0", k), dig0,  vecs[k].e_d0);
         check($sformatf("v%0d_busy", k), busy,  vecs[k].e_busy);
         if (vecs[k].mon != 0)
            check($sformatf("v%0d_monitor", k), mon_bad, 1'b0);
         if (vecs[k].e_period != 0) begin
            measure_period(per);
            check($sformatf("v%0d_period", k), per, vecs[k].e_period);
         end else begin
            check($sformatf("v%0d_buz", k), prbuz, 1'b0);
         end
      end

      // One-shot beep on button 3 (div 9): BEEP entered 7 cycles after the press.
      mode  = 1'b1;
      prbtn = 4'b0111;
      for (int t = 1; t <= 100; t++) begin
         @(negedge clk);
         buz_h[t]  = prbuz;
         busy_h[t] = busy;
         led_h[t]  = prled;
      end
      check("beep_busy_t7",  busy_h[7],  1'b0);
      check("beep_busy_t8",  busy_h[8],  1'b1);
      check("beep_led_t8",   led_h[8],   4'b1000);
      check("beep_buz_t16",  buz_h[16],  1'b0);
      check("beep_buz_t17",  buz_h[17],  1'b1);
      check("beep_buz_t26",  buz_h[26],  1'b1);
      check("beep_buz_t27",  buz_h[27],  1'b0);
      check("beep_buz_t37",  buz_h[37],  1'b1);
      check("beep_buz_t46",  buz_h[46],  1'b1);
      check("beep_buz_t47",  buz_h[47],  1'b0);
      check("beep_led_t48",  led_h[48],  4'b0000);
      check("beep_busy_t48", busy_h[48], 1'b1);
      check("beep_busy_t100", busy_h[100], 1'b1);
      rises = 0;
      for (int t = 9; t <= 47; t++) if (!buz_h[t-1] && buz_h[t]) rises++;
      check("beep_rises", rises, 2);
      rises = 0;
      for (int t = 47; t <= 100; t++) if (buz_h[t]) rises++;
      check("beep_no_retrigger", rises, 0);
      prbtn = 4'b1111;
      repeat (12) @(negedge clk);
      check("beep_rel_busy", busy,  1'b0);
      check("beep_rel_led",  prled, 4'b0000);
      check("beep_rel_dig1", dig1,  5'd20);

      // Reset in the middle of a beep on button 0 (div 3: buzzer high at tick 12).
      prbtn = 4'b1110;
      repeat (12) @(negedge clk);
      check("mid_busy_pre", busy,  1'b1);
      check("mid_buz_pre",  prbuz, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_led",  prled, 4'b0000);
      check("mid_rst_buz",  prbuz, 1'b0);
      check("mid_rst_busy", busy,  1'b0);
      check("mid_rst_dig1", dig1,  5'd20);
      check("mid_rst_dig0", dig0,  5'd20);
      prbtn = 4'b1111;
      @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      check("post_rst_busy", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
